// File: rtl/ddr_target_ccc_responder.sv
// Target-side HDR-DDR CCC responder: decodes broadcast/direct CCCs,
// maintains MWL/MRL/event-enable registers and returns GET payloads.
module ddr_target_ccc_responder #(
  parameter logic [6:0]  BCAST_ADDR = 7'h7E,
  parameter logic [15:0] MWL_RST    = 16'd256,
  parameter logic [15:0] MRL_RST    = 16'd256
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic [6:0]  i_dyn_addr,
  input  logic        i_rx_valid,
  input  logic [1:0]  i_rx_type,
  input  logic [15:0] i_rx_word,
  input  logic        i_rx_err,
  input  logic        i_hdr_restart,
  input  logic        i_hdr_exit,
  input  logic [15:0] i_status,
  input  logic        i_tx_ready,
  output logic        o_ack_valid,
  output logic        o_ack,
  output logic        o_tx_valid,
  output logic [15:0] o_tx_word,
  output logic        o_tx_last,
  output logic [15:0] o_mwl,
  output logic [15:0] o_mrl,
  output logic [7:0]  o_evt_en,
  output logic        o_ccc_done,
  output logic        o_ccc_err
);

  localparam logic [7:0] CCC_ENEC   = 8'h00;
  localparam logic [7:0] CCC_DISEC  = 8'h01;
  localparam logic [7:0] CCC_SETMWL = 8'h89;
  localparam logic [7:0] CCC_SETMRL = 8'h8A;
  localparam logic [7:0] CCC_GETMWL = 8'h8B;
  localparam logic [7:0] CCC_GETMRL = 8'h8C;
  localparam logic [7:0] CCC_GETSTS = 8'h90;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CODE,
    S_BC_DATA,
    S_DIR_CMD,
    S_DIR_WR,
    S_DIR_RD,
    S_WAIT_END
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_ccc, w_ccc_nxt;
  logic [7:0]  r_byte, w_byte_nxt;
  logic [15:0] r_stage, w_stage_nxt;
  logic        r_have, w_have_nxt;
  logic        r_rs_seen, w_rs_seen_nxt;
  logic        r_ack_valid, w_ack_valid_nxt;
  logic        r_ack, w_ack_nxt;
  logic        r_tx_valid, w_tx_valid_nxt;
  logic [15:0] r_tx_word, w_tx_word_nxt;
  logic        r_tx_last, w_tx_last_nxt;
  logic [15:0] r_mwl, w_mwl_nxt;
  logic [15:0] r_mrl, w_mrl_nxt;
  logic [7:0]  r_evt, w_evt_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;

  logic        w_cmd, w_dat, w_crc, w_rxerr;
  logic        w_rnw;
  logic [6:0]  w_addr;
  logic [7:0]  w_code;
  logic        w_is_set, w_is_get, w_code_dir;
  logic        w_in_bc, w_in_dir;
  logic [15:0] w_rd_val;

  assign w_cmd   = i_rx_valid && (i_rx_type == 2'd0);
  assign w_dat   = i_rx_valid && (i_rx_type == 2'd1);
  assign w_crc   = i_rx_valid && (i_rx_type == 2'd2);
  assign w_rxerr = i_rx_valid && i_rx_err && (i_rx_type != 2'd3);
  assign w_rnw   = i_rx_word[15];
  assign w_addr  = i_rx_word[7:1];
  assign w_code  = i_rx_word[15:8];

  assign w_is_set = (r_ccc == CCC_SETMWL) || (r_ccc == CCC_SETMRL);
  assign w_is_get = (r_ccc == CCC_GETMWL) || (r_ccc == CCC_GETMRL)
                 || (r_ccc == CCC_GETSTS);
  assign w_code_dir = (w_code == CCC_SETMWL) || (w_code == CCC_SETMRL)
                   || (w_code == CCC_GETMWL) || (w_code == CCC_GETMRL)
                   || (w_code == CCC_GETSTS);

  assign w_in_bc  = (r_state == S_CODE) || (r_state == S_BC_DATA);
  assign w_in_dir = (r_state == S_DIR_CMD) || (r_state == S_DIR_WR)
                 || (r_state == S_DIR_RD);

  always_comb begin
    w_rd_val = i_status;
    unique case (1'b1)
      (r_ccc == CCC_GETMWL): w_rd_val = r_mwl;
      (r_ccc == CCC_GETMRL): w_rd_val = r_mrl;
      default:               w_rd_val = i_status;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ccc_nxt       = r_ccc;
    w_byte_nxt      = r_byte;
    w_stage_nxt     = r_stage;
    w_have_nxt      = r_have;
    w_rs_seen_nxt   = r_rs_seen;
    w_ack_valid_nxt = 1'b0;
    w_ack_nxt       = 1'b0;
    w_tx_valid_nxt  = r_tx_valid;
    w_tx_word_nxt   = r_tx_word;
    w_tx_last_nxt   = r_tx_last;
    w_mwl_nxt       = r_mwl;
    w_mrl_nxt       = r_mrl;
    w_evt_nxt       = r_evt;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;

    if (i_hdr_exit) begin
      w_state_nxt    = S_IDLE;
      w_have_nxt     = 1'b0;
      w_rs_seen_nxt  = 1'b0;
      w_tx_valid_nxt = 1'b0;
      w_tx_last_nxt  = 1'b0;
    end else if (i_hdr_restart && w_in_bc) begin
      w_state_nxt = S_IDLE;
    end else if (i_hdr_restart && w_in_dir) begin
      w_state_nxt    = S_DIR_CMD;
      w_rs_seen_nxt  = 1'b1;
      w_have_nxt     = 1'b0;
      w_tx_valid_nxt = 1'b0;
      w_tx_last_nxt  = 1'b0;
    end else if (w_rxerr && (w_in_bc || w_in_dir)) begin
      // Any staged write is dropped with the abort.
      w_state_nxt    = S_WAIT_END;
      w_err_nxt      = 1'b1;
      w_have_nxt     = 1'b0;
      w_tx_valid_nxt = 1'b0;
      w_tx_last_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_cmd && !w_rnw && (w_addr == BCAST_ADDR))
            w_state_nxt = S_CODE;
        end
        S_CODE: begin
          if (w_dat) begin
            w_ccc_nxt  = w_code;
            w_byte_nxt = i_rx_word[7:0];
            if ((w_code == CCC_ENEC) || (w_code == CCC_DISEC)) begin
              w_state_nxt = S_BC_DATA;
            end else if (w_code_dir) begin
              w_state_nxt   = S_DIR_CMD;
              w_rs_seen_nxt = 1'b0;
            end else begin
              w_state_nxt = S_WAIT_END;
            end
          end else if (w_crc) begin
            w_state_nxt = S_WAIT_END;
            w_err_nxt   = 1'b1;
          end
        end
        S_BC_DATA: begin
          if (w_crc) begin
            if (r_ccc == CCC_ENEC) w_evt_nxt = r_evt | r_byte;
            else                   w_evt_nxt = r_evt & ~r_byte;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_WAIT_END;
          end
        end
        S_DIR_CMD: begin
          if (w_cmd && r_rs_seen) begin
            w_rs_seen_nxt = 1'b0;
            if (w_addr == i_dyn_addr) begin
              w_ack_valid_nxt = 1'b1;
              if (!w_rnw && w_is_set) begin
                w_ack_nxt   = 1'b1;
                w_have_nxt  = 1'b0;
                w_state_nxt = S_DIR_WR;
              end else if (w_rnw && w_is_get) begin
                w_ack_nxt      = 1'b1;
                w_tx_valid_nxt = 1'b1;
                w_tx_last_nxt  = 1'b1;
                w_tx_word_nxt  = w_rd_val;
                w_state_nxt    = S_DIR_RD;
              end else begin
                w_state_nxt = S_WAIT_END;
              end
            end
          end
        end
        S_DIR_WR: begin
          if (w_dat) begin
            w_stage_nxt = i_rx_word;
            w_have_nxt  = 1'b1;
          end else if (w_crc) begin
            w_have_nxt = 1'b0;
            if (r_have) begin
              if (r_ccc == CCC_SETMWL) w_mwl_nxt = r_stage;
              else                     w_mrl_nxt = r_stage;
              w_done_nxt    = 1'b1;
              w_rs_seen_nxt = 1'b0;
              w_state_nxt   = S_DIR_CMD;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_WAIT_END;
            end
          end
        end
        S_DIR_RD: begin
          if (r_tx_valid && i_tx_ready) begin
            w_tx_valid_nxt = 1'b0;
            w_tx_last_nxt  = 1'b0;
            w_done_nxt     = 1'b1;
            w_rs_seen_nxt  = 1'b0;
            w_state_nxt    = S_DIR_CMD;
          end
        end
        S_WAIT_END: begin
          w_state_nxt = S_WAIT_END;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state     <= S_IDLE;
      r_ccc       <= 8'h00;
      r_byte      <= 8'h00;
      r_stage     <= 16'h0000;
      r_have      <= 1'b0;
      r_rs_seen   <= 1'b0;
      r_ack_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_word   <= 16'h0000;
      r_tx_last   <= 1'b0;
      r_mwl       <= MWL_RST;
      r_mrl       <= MRL_RST;
      r_evt       <= 8'hFF;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ccc       <= w_ccc_nxt;
      r_byte      <= w_byte_nxt;
      r_stage     <= w_stage_nxt;
      r_have      <= w_have_nxt;
      r_rs_seen   <= w_rs_seen_nxt;
      r_ack_valid <= w_ack_valid_nxt;
      r_ack       <= w_ack_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_tx_word   <= w_tx_word_nxt;
      r_tx_last   <= w_tx_last_nxt;
      r_mwl       <= w_mwl_nxt;
      r_mrl       <= w_mrl_nxt;
      r_evt       <= w_evt_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign o_ack_valid = r_ack_valid;
  assign o_ack       = r_ack;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_word   = r_tx_word;
  assign o_tx_last   = r_tx_last;
  assign o_mwl       = r_mwl;
  assign o_mrl       = r_mrl;
  assign o_evt_en    = r_evt;
  assign o_ccc_done  = r_done;
  assign o_ccc_err   = r_err;

endmodule
